// File: rtl/alu_pkg.sv
// Shared command codes and flag-vector bit positions for the pipelined ALU.
package alu_pkg;

  localparam logic [3:0] CMD_ADD  = 4'd0;
  localparam logic [3:0] CMD_SUB  = 4'd1;
  localparam logic [3:0] CMD_XOR  = 4'd2;
  localparam logic [3:0] CMD_SLT  = 4'd3;
  localparam logic [3:0] CMD_AND  = 4'd4;
  localparam logic [3:0] CMD_NAND = 4'd5;
  localparam logic [3:0] CMD_OR   = 4'd6;
  localparam logic [3:0] CMD_NOR  = 4'd7;
  localparam logic [3:0] CMD_MUL  = 4'd8;

  // Bit positions inside the registered stage-2 flag vector.
  localparam int FLAG_CARRY = 0;
  localparam int FLAG_OVF   = 1;
  localparam int FLAG_ZERO  = 2;
  localparam int FLAG_ERR   = 3;
  localparam int FLAG_W     = 4;

endpackage

// File: rtl/alu_core.sv
// Combinational WIDTH-bit ALU: eight logic/arith ops plus carry/overflow/zero/err.
module alu_core
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CMD_W = 4
) (
  input  logic [CMD_W-1:0] i_command,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic [WIDTH-1:0] o_result,
  output logic             o_carryout,
  output logic             o_overflow,
  output logic             o_zero,
  output logic             o_err
);

  logic             w_is_sub;
  logic [WIDTH-1:0] w_b_op;
  logic [WIDTH:0]   w_sum;
  logic             w_ovf;
  logic             w_less;

  assign w_is_sub = (i_command == CMD_W'(CMD_SUB)) || (i_command == CMD_W'(CMD_SLT));
  assign w_b_op   = w_is_sub ? ~i_b : i_b;
  assign w_sum    = {1'b0, i_a} + {1'b0, w_b_op} + {{WIDTH{1'b0}}, w_is_sub};
  // Using the inverted B operand makes one overflow rule cover both add and subtract.
  assign w_ovf    = (i_a[WIDTH-1] == w_b_op[WIDTH-1]) && (w_sum[WIDTH-1] != i_a[WIDTH-1]);
  assign w_less   = w_sum[WIDTH-1] ^ w_ovf;

  always_comb begin
    o_result   = '0;
    o_carryout = 1'b0;
    o_overflow = 1'b0;
    o_err      = 1'b0;
    case (i_command)
      CMD_W'(CMD_ADD),
      CMD_W'(CMD_SUB): begin
        o_result   = w_sum[WIDTH-1:0];
        o_carryout = w_sum[WIDTH];
        o_overflow = w_ovf;
      end
      CMD_W'(CMD_SLT):  o_result = {{(WIDTH-1){1'b0}}, w_less};
      CMD_W'(CMD_XOR):  o_result = i_a ^ i_b;
      CMD_W'(CMD_AND):  o_result = i_a & i_b;
      CMD_W'(CMD_NAND): o_result = ~(i_a & i_b);
      CMD_W'(CMD_OR):   o_result = i_a | i_b;
      CMD_W'(CMD_NOR):  o_result = ~(i_a | i_b);
      default:          o_err = 1'b1;
    endcase
  end

  assign o_zero = (o_result == '0);

endmodule

// File: rtl/alu_pipe.sv
// Two-stage valid/ready pipelined ALU around alu_core.
// Define ALU_MUL_EN to add an iterative shift-add multiply (command 8) in stage 1.
module alu_pipe
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CMD_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [CMD_W-1:0] command,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carryout,
  output logic             overflow,
  output logic             zero,
  output logic             err
);

  logic              r_s1_valid;
  logic [CMD_W-1:0]  r_s1_cmd;
  logic [WIDTH-1:0]  r_s1_a;
  logic [WIDTH-1:0]  r_s1_b;
  logic              r_s2_valid;
  logic [WIDTH-1:0]  r_s2_result;
  logic [FLAG_W-1:0] r_s2_flags;

  logic              w_in_accept;
  logic              w_s2_load;
  logic              w_s1_done;
  logic              w_s1_advance;
  logic [WIDTH-1:0]  w_core_result;
  logic              w_core_carry;
  logic              w_core_ovf;
  logic              w_core_zero;
  logic              w_core_err;
  logic [WIDTH-1:0]  w_s1_result;
  logic [FLAG_W-1:0] w_s1_flags;

  alu_core #(
    .WIDTH(WIDTH),
    .CMD_W(CMD_W)
  ) u_core (
    .i_command (r_s1_cmd),
    .i_a       (r_s1_a),
    .i_b       (r_s1_b),
    .o_result  (w_core_result),
    .o_carryout(w_core_carry),
    .o_overflow(w_core_ovf),
    .o_zero    (w_core_zero),
    .o_err     (w_core_err)
  );

  assign w_s2_load    = !r_s2_valid || out_ready;
  assign w_s1_advance = r_s1_valid && w_s1_done && w_s2_load;
  assign in_ready     = !r_s1_valid || w_s1_advance;
  assign w_in_accept  = in_valid && in_ready;

`ifdef ALU_MUL_EN
  localparam int CNT_W = $clog2(WIDTH + 1);

  logic [CNT_W-1:0]   r_mul_cnt;
  logic [2*WIDTH-1:0] r_mul_acc;
  logic [2*WIDTH-1:0] r_mul_mcand;
  logic [WIDTH-1:0]   r_mul_mplr;
  logic               w_s1_is_mul;

  assign w_s1_is_mul = (r_s1_cmd == CMD_W'(CMD_MUL));
  // Counter is only ever nonzero while a multiply occupies stage 1.
  assign w_s1_done   = (r_mul_cnt == '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_mul_cnt   <= '0;
      r_mul_acc   <= '0;
      r_mul_mcand <= '0;
      r_mul_mplr  <= '0;
    end else if (w_in_accept && (command == CMD_W'(CMD_MUL))) begin
      r_mul_cnt   <= CNT_W'(WIDTH);
      r_mul_acc   <= '0;
      r_mul_mcand <= {{WIDTH{1'b0}}, a};
      r_mul_mplr  <= b;
    end else if (r_mul_cnt != '0) begin
      if (r_mul_mplr[0]) r_mul_acc <= r_mul_acc + r_mul_mcand;
      r_mul_mcand <= r_mul_mcand << 1;
      r_mul_mplr  <= r_mul_mplr >> 1;
      r_mul_cnt   <= r_mul_cnt - CNT_W'(1);
    end
  end

  always_comb begin
    w_s1_result = w_core_result;
    w_s1_flags  = '0;
    w_s1_flags[FLAG_CARRY] = w_core_carry;
    w_s1_flags[FLAG_OVF]   = w_core_ovf;
    w_s1_flags[FLAG_ZERO]  = w_core_zero;
    w_s1_flags[FLAG_ERR]   = w_core_err;
    if (w_s1_is_mul) begin
      w_s1_result = r_mul_acc[WIDTH-1:0];
      w_s1_flags[FLAG_CARRY] = |r_mul_acc[2*WIDTH-1:WIDTH];
      w_s1_flags[FLAG_OVF]   = 1'b0;
      w_s1_flags[FLAG_ZERO]  = (r_mul_acc[WIDTH-1:0] == '0);
      w_s1_flags[FLAG_ERR]   = 1'b0;
    end
  end
`else
  assign w_s1_done = 1'b1;

  always_comb begin
    w_s1_result = w_core_result;
    w_s1_flags  = '0;
    w_s1_flags[FLAG_CARRY] = w_core_carry;
    w_s1_flags[FLAG_OVF]   = w_core_ovf;
    w_s1_flags[FLAG_ZERO]  = w_core_zero;
    w_s1_flags[FLAG_ERR]   = w_core_err;
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_s1_valid <= 1'b0;
      r_s1_cmd   <= '0;
      r_s1_a     <= '0;
      r_s1_b     <= '0;
    end else if (w_in_accept) begin
      r_s1_valid <= 1'b1;
      r_s1_cmd   <= command;
      r_s1_a     <= a;
      r_s1_b     <= b;
    end else if (w_s1_advance) begin
      r_s1_valid <= 1'b0;
    end
  end

  // Data regs only change on a real advance so a drained output keeps its last value.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_s2_valid  <= 1'b0;
      r_s2_result <= '0;
      r_s2_flags  <= '0;
    end else if (w_s2_load) begin
      r_s2_valid <= w_s1_advance;
      if (w_s1_advance) begin
        r_s2_result <= w_s1_result;
        r_s2_flags  <= w_s1_flags;
      end
    end
  end

  assign out_valid = r_s2_valid;
  assign result    = r_s2_result;
  assign carryout  = r_s2_flags[FLAG_CARRY];
  assign overflow  = r_s2_flags[FLAG_OVF];
  assign zero      = r_s2_flags[FLAG_ZERO];
  assign err       = r_s2_flags[FLAG_ERR];

endmodule

// File: tb/tb_alu_pipe.sv
// Scoreboard bench for alu_pipe (WIDTH=32); MUL checks compile in when ALU_MUL_EN is defined.
module tb_alu_pipe;

  localparam int W = 32;

  typedef struct {
    logic [W-1:0] res;
    logic         c;
    logic         v;
    logic         z;
    logic         e;
  } exp_t;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [3:0]   command = '0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] result;
  logic         carryout, overflow, zero, err;

  int   n_tests = 0;
  int   n_fail  = 0;
  int   n_beats = 0;
  exp_t sb[$];
  logic hold_vld = 1'b0;
  exp_t hold;
  logic saw_blocked = 1'b0;

  alu_pipe #(.WIDTH(W), .CMD_W(4)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .command(command), .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .carryout(carryout), .overflow(overflow), .zero(zero), .err(err)
  );

  always #5 clk = ~clk;

  function automatic exp_t mk(input logic [W-1:0] r, input logic c, input logic v,
                              input logic z, input logic e);
    exp_t x;
    x.res = r; x.c = c; x.v = v; x.z = z; x.e = e;
    return x;
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, want);
    end
  endtask

  // Monitor: pops the scoreboard on every output transfer, checks stability while stalled.
  always @(negedge clk) begin
    if (!reset && in_valid && !in_ready) saw_blocked = 1'b1;
    if (!reset && out_valid) begin
      if (!out_ready) begin
        if (hold_vld) begin
          n_tests++;
          if (result !== hold.res || carryout !== hold.c || overflow !== hold.v ||
              zero !== hold.z || err !== hold.e) begin
            n_fail++;
            $display("FAIL stall_stable: got r=%h c%b v%b z%b e%b held r=%h c%b v%b z%b e%b",
                     result, carryout, overflow, zero, err,
                     hold.res, hold.c, hold.v, hold.z, hold.e);
          end
        end
        hold = mk(result, carryout, overflow, zero, err);
        hold_vld = 1'b1;
      end else begin
        hold_vld = 1'b0;
        n_tests++;
        n_beats++;
        if (sb.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_beat: got r=%h with empty scoreboard", result);
        end else begin
          exp_t e;
          e = sb.pop_front();
          if (result !== e.res || carryout !== e.c || overflow !== e.v ||
              zero !== e.z || err !== e.e) begin
            n_fail++;
            $display("FAIL beat%0d: got r=%h c%b v%b z%b e%b expected r=%h c%b v%b z%b e%b",
                     n_beats, result, carryout, overflow, zero, err,
                     e.res, e.c, e.v, e.z, e.e);
          end
        end
      end
    end
  end

  task automatic issue(input logic [3:0] cmd, input logic [W-1:0] op_a,
                       input logic [W-1:0] op_b, input exp_t e);
    logic ok;
    int   tries;
    command  = cmd;
    a        = op_a;
    b        = op_b;
    in_valid = 1'b1;
    tries    = 0;
    ok       = 1'b0;
    while (!ok && tries < 200) begin
      @(negedge clk);
      ok = in_ready;
      if (ok) sb.push_back(e);
      @(posedge clk);
      tries++;
    end
    #1;
    in_valid = 1'b0;
    if (!ok) begin
      n_tests++;
      n_fail++;
      $display("FAIL issue_timeout: cmd %0d never accepted", cmd);
    end
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("drain", 64'(sb.size()), 64'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    int lat;
    int low_cnt;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("reset_out_valid", 64'(out_valid), 64'd0);
    check("reset_result", 64'(result), 64'd0);
    check("reset_flags", 64'({carryout, overflow, zero, err}), 64'd0);
    check("reset_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #1;

    // Latency: output visible after the second edge following acceptance.
    issue(4'd0, 32'h7ffffffe, 32'h00000002, mk(32'h80000000, 0, 1, 0, 0));
    lat = 0;
    while (!out_valid && lat < 10) begin @(negedge clk); lat++; end
    check("latency", 64'(lat), 64'd2);
    drain();

    issue(4'd0, 32'h80000000, 32'hffffffff, mk(32'h7fffffff, 1, 1, 0, 0));
    issue(4'd0, 32'hffffffff, 32'h00000001, mk(32'h00000000, 1, 0, 1, 0));
    issue(4'd1, 32'h7fffffff, 32'h7ffffffe, mk(32'h00000001, 1, 0, 0, 0));
    issue(4'd1, 32'hfffffffe, 32'h7fffffff, mk(32'h7fffffff, 1, 1, 0, 0));
    issue(4'd3, 32'hffffffff, 32'h00000001, mk(32'h00000001, 0, 0, 0, 0));
    issue(4'd3, 32'h00000001, 32'hffffffff, mk(32'h00000000, 0, 0, 1, 0));
    issue(4'd3, 32'h00000000, 32'h00000000, mk(32'h00000000, 0, 0, 1, 0));
    issue(4'd3, 32'h80000000, 32'h00000001, mk(32'h00000001, 0, 0, 0, 0));
    issue(4'd2, 32'hf0f0f0f0, 32'hff00ff00, mk(32'h0ff00ff0, 0, 0, 0, 0));
    issue(4'd2, 32'h12345678, 32'h12345678, mk(32'h00000000, 0, 0, 1, 0));
    issue(4'd4, 32'hf0f0f0f0, 32'hff00ff00, mk(32'hf000f000, 0, 0, 0, 0));
    issue(4'd5, 32'hf0f0f0f0, 32'hff00ff00, mk(32'h0fff0fff, 0, 0, 0, 0));
    issue(4'd6, 32'hf0f0f0f0, 32'hff00ff00, mk(32'hfff0fff0, 0, 0, 0, 0));
    issue(4'd7, 32'hf0f0f0f0, 32'hff00ff00, mk(32'h000f000f, 0, 0, 0, 0));
    issue(4'd9, 32'h00000005, 32'h00000006, mk(32'h00000000, 0, 0, 1, 1));
    issue(4'd0, 32'h00000001, 32'h00000002, mk(32'h00000003, 0, 0, 0, 0));
    issue(4'd15, 32'hffffffff, 32'hffffffff, mk(32'h00000000, 0, 0, 1, 1));
    drain();

    // Stream of 8 ADDs with a 3-cycle output stall mid-stream.
    saw_blocked = 1'b0;
    fork
      begin
        for (int k = 0; k < 8; k++)
          issue(4'd0, W'(k), 32'd100, mk(W'(k + 100), 0, 0, 0, 0));
      end
      begin
        repeat (3) @(posedge clk);
        #1 out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    drain();
    check("stall_in_ready_drop", 64'(saw_blocked), 64'd1);

    // Reset one cycle after accept discards the op.
    issue(4'd0, 32'h00000010, 32'h00000020, mk(32'h00000030, 0, 0, 0, 0));
    reset = 1'b1;
    sb.delete();
    @(posedge clk); #1;
    reset = 1'b0;
    lat = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (out_valid) lat++;
    end
    check("reset_discard", 64'(lat), 64'd0);
    @(posedge clk); #1;
    issue(4'd1, 32'h00000050, 32'h00000010, mk(32'h00000040, 1, 0, 0, 0));
    lat = 0;
    while (!out_valid && lat < 10) begin @(negedge clk); lat++; end
    check("latency_after_reset", 64'(lat), 64'd2);
    drain();

`ifdef ALU_MUL_EN
    issue(4'd8, 32'h10000000, 32'h00000011, mk(32'h10000000, 1, 0, 0, 0));
    low_cnt = 0;
    for (int k = 0; k < 3 * W; k++) begin
      @(negedge clk);
      if (!in_ready) low_cnt++;
    end
    check("mul_busy_cycles", 64'(low_cnt), 64'(W));
    drain();
    issue(4'd8, 32'h00000003, 32'h00000005, mk(32'h0000000f, 0, 0, 0, 0));
    issue(4'd0, 32'h00000002, 32'h00000002, mk(32'h00000004, 0, 0, 0, 0));
    drain();
`else
    low_cnt = 0;
    issue(4'd8, 32'h00000003, 32'h00000005, mk(32'h00000000, 0, 0, 1, 1));
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (!in_ready) low_cnt++;
    end
    check("mul_disabled_no_busy", 64'(low_cnt), 64'd0);
    drain();
`endif

    check("beats_total_min", 64'(n_beats >= 27), 64'd1);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
